// File: rtl/branch_resolve.sv
// Redirect arbiter between EX and PC: tracks each fetched address with its prediction,
// resolves it against the EX result, and emits a one-cycle registered jump/flush pulse.
`ifndef BRANCH_RESOLVE_DEFS
`define BRANCH_RESOLVE_DEFS
`define HOLDPIP_BUS                   2:0
`define HOLD_NO                       3'b000
`define INST_ADDR_BUS                 31:0
`define INST_ADDR_BUS_WIDTH           32
`define JUMP_CAUSE_BUS                2:0
`define JUMP_CAUSE_NO                 3'd0
`define JUMP_CAUSE_EXCEPTION          3'd1
`define JUMP_CAUSE_INTERRUPT          3'd2
`define JUMP_CAUSE_NOCONDITION        3'd3
`define JUMP_CAUSE_PREDICT_NO_BUT_YES 3'd4
`define JUMP_CAUSE_PREDICT_YES_BUT_NO 3'd5
`endif

module branch_resolve #(
  parameter int DEPTH     = 4,
  parameter int CNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   jtag_reset_i,
  input  logic [`HOLDPIP_BUS]    hold_flag_i,
  input  logic [`INST_ADDR_BUS]  fetch_addr_i,
  input  logic                   predict_jump_i,
  input  logic                   ex_valid_i,
  input  logic                   ex_is_branch_i,
  input  logic                   ex_is_jump_i,
  input  logic                   ex_taken_i,
  input  logic [`INST_ADDR_BUS]  ex_pc_i,
  input  logic [`INST_ADDR_BUS]  ex_target_i,
  input  logic                   exc_req_i,
  input  logic [`INST_ADDR_BUS]  exc_vector_i,
  input  logic                   irq_req_i,
  input  logic [`INST_ADDR_BUS]  irq_vector_i,
  output logic [`JUMP_CAUSE_BUS] jump_cause_o,
  output logic [`INST_ADDR_BUS]  jump_from_addr_o,
  output logic [`INST_ADDR_BUS]  jump_to_addr_o,
  output logic                   flush_o,
  output logic [CNT_WIDTH-1:0]   branch_cnt_o,
  output logic [CNT_WIDTH-1:0]   mispredict_cnt_o,
  output logic                   err_o
);

  localparam int AW = `INST_ADDR_BUS_WIDTH;
  localparam int PW = $clog2(DEPTH);

  typedef logic [AW-1:0] addr_t;
  typedef logic [PW-1:0] ptr_t;
  typedef logic [PW:0]   cnt_t;
  typedef logic [CNT_WIDTH-1:0] perf_t;

  localparam cnt_t FULL_CNT = cnt_t'(DEPTH);

  addr_t            addr_q [DEPTH];
  logic [DEPTH-1:0] pred_q;
  ptr_t             head_q, head_d, tail_q, tail_d;
  cnt_t             cnt_q, cnt_d;

  logic [`JUMP_CAUSE_BUS] cause_q, cause_d;
  addr_t from_q, from_d, to_q, to_d;
  perf_t bcnt_q, bcnt_d, mcnt_q, mcnt_d;
  logic  err_q, err_d;

  logic  run, push, pop, empty, full, hit, pred, deq, ovf;
  logic  br_res, misp;
  addr_t head_addr, irq_from;

  // A pulse in flight means the instructions behind it are wrong-path.
  assign flush_o = (cause_q != `JUMP_CAUSE_NO);
  assign run     = (hold_flag_i == `HOLD_NO) && !flush_o;
  assign push    = run;
  assign pop     = run && ex_valid_i;

  assign empty     = (cnt_q == '0);
  assign full      = (cnt_q == FULL_CNT);
  assign head_addr = addr_q[head_q];
  assign hit       = !empty && (head_addr == ex_pc_i);
  assign pred      = hit && pred_q[head_q];
  assign ovf       = push && full && !pop;
  assign deq       = (pop && !empty) || ovf;

  // With nothing from EX, the oldest in-flight instruction is the interrupt return point;
  // an empty queue means that is the one being fetched right now.
  assign irq_from = ex_valid_i ? ex_pc_i : (empty ? fetch_addr_i : head_addr);

  always_comb begin
    head_d = head_q + ptr_t'(deq);
    tail_d = tail_q + ptr_t'(push);
    cnt_d  = cnt_q + cnt_t'(push) - cnt_t'(deq);
    if (flush_o) begin
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
    end
  end

  always_comb begin
    cause_d = `JUMP_CAUSE_NO;
    from_d  = '0;
    to_d    = '0;
    br_res  = 1'b0;
    misp    = 1'b0;
    if (run) begin
      if (exc_req_i) begin
        cause_d = `JUMP_CAUSE_EXCEPTION;
        from_d  = ex_pc_i;
        to_d    = exc_vector_i;
      end else if (irq_req_i) begin
        cause_d = `JUMP_CAUSE_INTERRUPT;
        from_d  = irq_from;
        to_d    = irq_vector_i;
      end else if (ex_valid_i && ex_is_jump_i) begin
        cause_d = `JUMP_CAUSE_NOCONDITION;
        from_d  = ex_pc_i;
        to_d    = ex_target_i;
      end else if (ex_valid_i && ex_is_branch_i) begin
        br_res = 1'b1;
        if (!pred && ex_taken_i) begin
          cause_d = `JUMP_CAUSE_PREDICT_NO_BUT_YES;
          from_d  = ex_pc_i;
          to_d    = ex_target_i;
          misp    = 1'b1;
        end else if (pred && !ex_taken_i) begin
          cause_d = `JUMP_CAUSE_PREDICT_YES_BUT_NO;
          from_d  = ex_pc_i;
          to_d    = ex_pc_i + addr_t'(4);
          misp    = 1'b1;
        end
      end
    end
  end

  always_comb begin
    bcnt_d = bcnt_q;
    mcnt_d = mcnt_q;
    if (br_res && (bcnt_q != '1)) bcnt_d = bcnt_q + perf_t'(1);
    if (misp && (mcnt_q != '1))   mcnt_d = mcnt_q + perf_t'(1);
    err_d = err_q | ovf | (pop && !hit);
  end

  // Entry storage needs no reset: occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= fetch_addr_i;
      pred_q[tail_q] <= predict_jump_i;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
      cause_q <= `JUMP_CAUSE_NO;
      from_q  <= '0;
      to_q    <= '0;
      bcnt_q  <= '0;
      mcnt_q  <= '0;
      err_q   <= 1'b0;
    end else if (jtag_reset_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
      cause_q <= `JUMP_CAUSE_NO;
      from_q  <= '0;
      to_q    <= '0;
      bcnt_q  <= '0;
      mcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
      from_q  <= from_d;
      to_q    <= to_d;
      bcnt_q  <= bcnt_d;
      mcnt_q  <= mcnt_d;
      err_q   <= err_d;
    end
  end

  assign jump_cause_o     = cause_q;
  assign jump_from_addr_o = from_q;
  assign jump_to_addr_o   = to_q;
  assign branch_cnt_o     = bcnt_q;
  assign mispredict_cnt_o = mcnt_q;
  assign err_o            = err_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Vector-table bench for branch_resolve: per-cycle stimulus rows carry hand-derived
// expected outputs, queued when driven and compared one clock later.
`ifndef BRANCH_RESOLVE_DEFS
`define BRANCH_RESOLVE_DEFS
`define HOLDPIP_BUS                   2:0
`define HOLD_NO                       3'b000
`define INST_ADDR_BUS                 31:0
`define INST_ADDR_BUS_WIDTH           32
`define JUMP_CAUSE_BUS                2:0
`define JUMP_CAUSE_NO                 3'd0
`define JUMP_CAUSE_EXCEPTION          3'd1
`define JUMP_CAUSE_INTERRUPT          3'd2
`define JUMP_CAUSE_NOCONDITION        3'd3
`define JUMP_CAUSE_PREDICT_NO_BUT_YES 3'd4
`define JUMP_CAUSE_PREDICT_YES_BUT_NO 3'd5
`endif

module tb_branch_resolve;
  localparam int CW = 4;
  localparam int NV = 41;
  localparam logic [1:0] N = 2'd0, B = 2'd1, J = 2'd2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          jtag;
  logic [2:0]    hold;
  logic [31:0]   fetch_addr, ex_pc, ex_target, exc_vector, irq_vector;
  logic          predict, ex_valid, ex_branch, ex_jump, ex_taken, exc_req, irq_req;
  logic [2:0]    cause;
  logic [31:0]   from_a, to_a;
  logic          flush, err;
  logic [CW-1:0] bcnt, mcnt;

  always #5 clk = ~clk;

  branch_resolve #(.DEPTH(4), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst), .jtag_reset_i(jtag), .hold_flag_i(hold),
    .fetch_addr_i(fetch_addr), .predict_jump_i(predict),
    .ex_valid_i(ex_valid), .ex_is_branch_i(ex_branch), .ex_is_jump_i(ex_jump),
    .ex_taken_i(ex_taken), .ex_pc_i(ex_pc), .ex_target_i(ex_target),
    .exc_req_i(exc_req), .exc_vector_i(exc_vector),
    .irq_req_i(irq_req), .irq_vector_i(irq_vector),
    .jump_cause_o(cause), .jump_from_addr_o(from_a), .jump_to_addr_o(to_a),
    .flush_o(flush), .branch_cnt_o(bcnt), .mispredict_cnt_o(mcnt), .err_o(err)
  );

  typedef struct {
    logic [2:0]    c;
    logic [31:0]   f, t;
    logic          cf;
    logic [CW-1:0] b, m;
    logic          e;
  } exp_t;

  typedef struct {
    logic        jt, hd;
    logic [31:0] fa;
    logic        pr;
    logic [1:0]  ek;
    logic        tk;
    logic [31:0] pc, tg;
    logic        ex, iq;
    exp_t        x;
  } vec_t;

  vec_t tbl [NV];
  exp_t sb [$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t v(input logic jt, input logic hd, input logic [31:0] fa,
                             input logic pr, input logic [1:0] ek, input logic tk,
                             input logic [31:0] pc, input logic [31:0] tg,
                             input logic ex, input logic iq, input logic [2:0] c,
                             input logic [31:0] f, input logic [31:0] t, input logic cf,
                             input int b, input int m, input logic e);
    vec_t r;
    r.jt = jt; r.hd = hd; r.fa = fa; r.pr = pr; r.ek = ek; r.tk = tk;
    r.pc = pc; r.tg = tg; r.ex = ex; r.iq = iq;
    r.x.c = c; r.x.f = f; r.x.t = t; r.x.cf = cf;
    r.x.b = CW'(b); r.x.m = CW'(m); r.x.e = e;
    return r;
  endfunction

  task automatic drive(input vec_t r);
    jtag       = r.jt;
    hold       = r.hd ? 3'b010 : `HOLD_NO;
    fetch_addr = r.fa;
    predict    = r.pr;
    ex_valid   = (r.ek != N);
    ex_branch  = (r.ek == B);
    ex_jump    = (r.ek == J);
    ex_taken   = r.tk;
    ex_pc      = r.pc;
    ex_target  = r.tg;
    exc_req    = r.ex;
    irq_req    = r.iq;
  endtask

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s [%0d]: got 0x%0h, expected 0x%0h", nm, id, act, exp);
    end
  endtask

  task automatic cmp(input exp_t x, input int id);
    chk("cause", id, 32'(cause), 32'(x.c));
    chk("flush", id, 32'(flush), 32'(x.c != `JUMP_CAUSE_NO));
    if (x.c != `JUMP_CAUSE_NO) begin
      chk("to", id, to_a, x.t);
      if (x.cf) chk("from", id, from_a, x.f);
    end
    chk("branch_cnt", id, 32'(bcnt), 32'(x.b));
    chk("mispredict_cnt", id, 32'(mcnt), 32'(x.m));
    chk("err", id, 32'(err), 32'(x.e));
  endtask

  initial begin
    exp_t z, x;
    logic [31:0] prev;
    z = '{c: `JUMP_CAUSE_NO, f: 0, t: 0, cf: 1'b0, b: 0, m: 0, e: 1'b0};

    tbl[0]  = v(0,0,'h100,1,N,0,0,0,0,0, `JUMP_CAUSE_NO,0,0,0, 0,0,0);
    tbl[1]  = v(0,0,'h104,0,B,0,'h100,0,0,0, `JUMP_CAUSE_PREDICT_YES_BUT_NO,'h100,'h104,1, 1,1,0);
    tbl[2]  = v(0,0,'h108,0,N,0,0,0,0,0, `JUMP_CAUSE_NO,0,0,0, 1,1,0);
    tbl[3]  = v(1,0,0,0,N,0,0,0,0,0, `JUMP_CAUSE_NO,0,0,0, 0,0,0);
    tbl[4]  = v(0,0,'h200,0,N,0,0,0,0,0, `JUMP_CAUSE_NO,0,0,0, 0,0,0);
    tbl[5]  = v(0,0,'h204,0,B,1,'h200,'h180,0,0, `JUMP_CAUSE_PREDICT_NO_BUT_YES,'h200,'h180,1, 1,1,0);
    tbl[6]  = v(0,0,'h180,0,N,0,0,0,0,0, `JUMP_CAUSE_NO,0,0,0, 1,1,0);
    tbl[7]  = v(0,0,'h300,1,N,0,0,0,0,0, `JUMP_CAUSE_NO,0,0,0, 1,1,0);
    tbl[8]  = v(0,0,'h304,0,B,1,'h300,'h340,0,0, `JUMP_CAUSE_NO,0,0,0, 2,1,0);
    tbl[9]  = v(0,0,'h308,0,B,0,'h304,0,0,0, `JUMP_CAUSE_NO,0,0,0, 3,1,0);
    tbl[10] = v(0,0,'h30c,0,J,0,'h308,'h500,0,0, `JUMP_CAUSE_NOCONDITION,'h308,'h500,1, 3,1,0);
    tbl[11] = v(0,0,'h500,0,N,0,0,0,0,0, `JUMP_CAUSE_NO,0,0,0, 3,1,0);
    tbl[12] = v(0,0,'h600,0,N,0,0,0,0,0, `JUMP_CAUSE_NO,0,0,0, 3,1,0);
    tbl[13] = v(0,0,'h604,0,B,1,'h600,'h700,1,0, `JUMP_CAUSE_EXCEPTION,'h600,'h8,1, 3,1,0);
    tbl[14] = v(0,0,'h608,0,N,0,0,0,0,0, `JUMP_CAUSE_NO,0,0,0, 3,1,0);
    tbl[15] = v(0,0,'h800,1,N,0,0,0,0,0, `JUMP_CAUSE_NO,0,0,0, 3,1,0);
    tbl[16] = v(0,1,'h804,0,B,0,'h800,0,0,0, `JUMP_CAUSE_NO,0,0,0, 3,1,0);
    tbl[17] = v(0,1,'h804,0,B,0,'h800,0,0,0, `JUMP_CAUSE_NO,0,0,0, 3,1,0);
    tbl[18] = v(0,1,'h804,0,B,0,'h800,0,0,0, `JUMP_CAUSE_NO,0,0,0, 3,1,0);
    tbl[19] = v(0,0,'h804,0,B,0,'h800,0,0,0, `JUMP_CAUSE_PREDICT_YES_BUT_NO,'h800,'h804,1, 4,2,0);
    tbl[20] = v(0,0,'h900,0,B,1,'h804,'h990,0,1, `JUMP_CAUSE_NO,0,0,0, 4,2,0);
    tbl[21] = v(0,0,'ha00,0,N,0,0,0,0,1, `JUMP_CAUSE_INTERRUPT,0,'h40,0, 4,2,0);
    tbl[22] = v(0,0,'ha04,0,N,0,0,0,0,0, `JUMP_CAUSE_NO,0,0,0, 4,2,0);
    tbl[23] = v(0,0,'hb00,0,N,0,0,0,0,0, `JUMP_CAUSE_NO,0,0,0, 4,2,0);
    tbl[24] = v(0,0,'hb04,0,B,1,'hb00,'hb80,0,1, `JUMP_CAUSE_INTERRUPT,'hb00,'h40,1, 4,2,0);
    tbl[25] = v(0,0,'hb08,0,N,0,0,0,0,0, `JUMP_CAUSE_NO,0,0,0, 4,2,0);
    tbl[26] = v(0,0,'hfffffffc,1,N,0,0,0,0,0, `JUMP_CAUSE_NO,0,0,0, 4,2,0);
    tbl[27] = v(0,0,'h0,0,B,0,'hfffffffc,0,0,0, `JUMP_CAUSE_PREDICT_YES_BUT_NO,'hfffffffc,'h0,1, 5,3,0);
    tbl[28] = v(0,0,'h4,0,N,0,0,0,0,0, `JUMP_CAUSE_NO,0,0,0, 5,3,0);
    tbl[29] = v(0,0,'hc00,1,N,0,0,0,0,0, `JUMP_CAUSE_NO,0,0,0, 5,3,0);
    tbl[30] = v(0,0,'hc10,0,B,0,'hc04,0,0,0, `JUMP_CAUSE_NO,0,0,0, 6,3,1);
    tbl[31] = v(1,0,0,0,N,0,0,0,0,0, `JUMP_CAUSE_NO,0,0,0, 0,0,0);
    tbl[32] = v(0,0,'hd00,0,N,0,0,0,0,0, `JUMP_CAUSE_NO,0,0,0, 0,0,0);
    tbl[33] = v(0,0,'hd04,1,N,0,0,0,0,0, `JUMP_CAUSE_NO,0,0,0, 0,0,0);
    tbl[34] = v(0,0,'hd08,0,N,0,0,0,0,0, `JUMP_CAUSE_NO,0,0,0, 0,0,0);
    tbl[35] = v(0,0,'hd0c,0,N,0,0,0,0,0, `JUMP_CAUSE_NO,0,0,0, 0,0,0);
    tbl[36] = v(0,0,'hd10,0,N,0,0,0,0,0, `JUMP_CAUSE_NO,0,0,0, 0,0,1);
    tbl[37] = v(0,0,'hd14,0,B,0,'hd04,0,0,0, `JUMP_CAUSE_PREDICT_YES_BUT_NO,'hd04,'hd08,1, 1,1,1);
    tbl[38] = v(0,0,'hd18,0,N,0,0,0,0,0, `JUMP_CAUSE_NO,0,0,0, 1,1,1);
    tbl[39] = v(1,0,0,0,N,0,0,0,0,0, `JUMP_CAUSE_NO,0,0,0, 0,0,0);
    tbl[40] = v(0,0,'he00,0,B,0,'he00,0,0,0, `JUMP_CAUSE_NO,0,0,0, 1,0,1);

    exc_vector = 32'h8;
    irq_vector = 32'h40;
    drive(v(0,0,0,0,N,0,0,0,0,0, 0,0,0,0, 0,0,0));
    repeat (2) @(posedge clk);
    #1;
    cmp(z, -1);
    chk("reset_from", -1, from_a, 32'h0);
    chk("reset_to", -1, to_a, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i]);
      sb.push_back(tbl[i].x);
      @(posedge clk);
      #1;
      x = sb.pop_front();
      cmp(x, i);
    end

    // Correctly predicted branches every cycle drive branch_cnt into saturation.
    prev = 32'he00;
    for (int k = 1; k <= 16; k++) begin
      drive(v(0,0,32'hf000 + 32'(4*k),0,B,0,prev,0,0,0, 0,0,0,0, 0,0,0));
      prev = 32'hf000 + 32'(4*k);
      @(posedge clk);
      #1;
      chk("sat_flush", 100 + k, 32'(flush), 32'h0);
    end
    chk("sat_branch_cnt", 117, 32'(bcnt), 32'(4'hf));
    chk("sat_mispredict_cnt", 117, 32'(mcnt), 32'h0);

    // Async reset while a redirect pulse is on the outputs.
    drive(v(0,0,32'hf100,0,B,1,prev,32'h7000,0,0, 0,0,0,0, 0,0,0));
    @(posedge clk);
    #1;
    chk("pre_rst_cause", 200, 32'(cause), 32'(`JUMP_CAUSE_PREDICT_NO_BUT_YES));
    chk("pre_rst_to", 200, to_a, 32'h7000);
    chk("pre_rst_flush", 200, 32'(flush), 32'h1);
    drive(v(0,0,0,0,N,0,0,0,0,0, 0,0,0,0, 0,0,0));
    #1 rst = 1'b1;
    #1;
    cmp(z, 201);
    chk("rst_from", 201, from_a, 32'h0);
    chk("rst_to", 201, to_a, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
